// File: rtl/div_pkg.sv
// div_pkg: scheduler state encoding and default operand width shared by the divider files.
package div_pkg;
   localparam int default_size = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_div_core.sv
// seq_div_core: restoring shift-subtract divider, one quotient bit per step.
module seq_div_core #(
   parameter int size = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [size-1:0] dvnd,
   input  logic [size-1:0] dvsr,
   output logic [size-1:0] quo,
   output logic [size-1:0] rem,
   output logic            dbz,
   output logic            last
);
   localparam int cw = $clog2(size + 1);
   logic [size-1:0] div;
   logic [size-1:0] diff;
   logic [cw-1:0]   cnt;
   logic [size:0]   shifted;
   logic            fits;
   assign shifted = {rem, quo[size-1]};
   assign fits    = shifted >= {1'b0, div};
   assign diff    = shifted[size-1:0] - div;
   assign dbz     = div == '0;
   assign last    = cnt == cw'(size - 1);
   // a zero divisor loads the final answer directly: all-ones quotient, dividend as remainder
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         quo <= '0;
         rem <= '0;
         div <= '0;
         cnt <= '0;
      end else if (load) begin
         div <= dvsr;
         cnt <= '0;
         quo <= dvsr == '0 ? '1 : dvnd;
         rem <= dvsr == '0 ? dvnd : '0;
      end else if (step) begin
         rem <= fits ? diff : shifted[size-1:0];
         quo <= {quo[size-2:0], fits};
         cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/div_sched.sv
// div_sched: two-requester round-robin front end sequencing one shared restoring divider.
module div_sched
   import div_pkg::*;
#(
   parameter int size = default_size
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic [size-1:0] req0_dvnd,
   input  logic [size-1:0] req0_dvsr,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [size-1:0] req1_dvnd,
   input  logic [size-1:0] req1_dvsr,
   output logic            req1_ready,
   output logic            rsp_valid,
   output logic            rsp_id,
   output logic [size-1:0] rsp_quo,
   output logic [size-1:0] rsp_rem,
   output logic            rsp_dbz,
   input  logic            rsp_ready,
   output logic            busy
);
   state_t          state, next;
   logic            ptr, id, grant, hs, last, dbz;
   logic [size-1:0] quo, rem, sel_dvsr;
   // ptr names the requester that wins when both are valid
   assign grant    = req0_valid & req1_valid ? ptr : req1_valid;
   assign hs       = req0_ready | req1_ready;
   assign sel_dvsr = grant ? req1_dvsr : req0_dvsr;

   seq_div_core #(.size(size)) core (
      .clk (clk),
      .rst (rst),
      .load(hs),
      .step(state == RUN),
      .dvnd(grant ? req1_dvnd : req0_dvnd),
      .dvsr(sel_dvsr),
      .quo (quo),
      .rem (rem),
      .dbz (dbz),
      .last(last)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         ptr   <= 1'b0;
         id    <= 1'b0;
      end else begin
         state <= next;
         ptr   <= hs ? ~grant : ptr;
         id    <= hs ? grant : id;
      end

   always_comb
      next = state == IDLE ? (hs ? (sel_dvsr == '0 ? DONE : RUN) : IDLE)
           : state == RUN  ? (last ? DONE : RUN)
           : (rsp_ready ? IDLE : DONE);

   always_comb begin
      req0_ready = ~rst & state == IDLE & req0_valid & ~grant;
      req1_ready = ~rst & state == IDLE & req1_valid & grant;
      rsp_valid  = state == DONE;
      rsp_id     = rsp_valid & id;
      rsp_quo    = rsp_valid ? quo : '0;
      rsp_rem    = rsp_valid ? rem : '0;
      rsp_dbz    = rsp_valid & dbz;
      busy       = state != IDLE;
   end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed requests against a cycle-level behavioural model of the divider scheduler.
module tb_div_sched;
   localparam int size = 4;
   logic       clk = 0, rst = 1;
   logic       req0_valid = 0, req1_valid = 0, rsp_ready = 0;
   logic [3:0] req0_dvnd = 0, req0_dvsr = 0, req1_dvnd = 0, req1_dvsr = 0;
   logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_dbz, busy;
   logic [3:0] rsp_quo, rsp_rem;
   int         passed = 0, total = 0, cyc = 0, due = 0, lat;
   logic       m_busy = 0, m_last = 1, e_id = 0, e_dbz = 0, g, show, x0, x1;
   logic [3:0] e_q = 0, e_r = 0, a, b, hq, hr;

   div_sched #(.size(size)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_dvnd(req0_dvnd), .req0_dvsr(req0_dvsr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_dvnd(req1_dvnd), .req1_dvsr(req1_dvsr), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quo(rsp_quo), .rsp_rem(rsp_rem),
      .rsp_dbz(rsp_dbz), .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // model state advances on each rising edge from the inputs presented during the cycle
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0;
         m_last = 1;
      end else if (m_busy) begin
         if (cyc >= due && rsp_ready) m_busy = 0;
      end else if (req0_valid || req1_valid) begin
         g      = req0_valid && req1_valid ? ~m_last : req1_valid;
         a      = g ? req1_dvnd : req0_dvnd;
         b      = g ? req1_dvsr : req0_dvsr;
         m_busy = 1;
         m_last = g;
         e_id   = g;
         e_dbz  = b == 0;
         e_q    = b == 0 ? 4'hF : a / b;
         e_r    = b == 0 ? a : a % b;
         due    = cyc + 1 + (b == 0 ? 0 : size);
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs", {busy, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_dbz, rsp_quo, rsp_rem}, 0);
         m_busy = 0;
         m_last = 1;
      end else begin
         g    = req0_valid && req1_valid ? ~m_last : req1_valid;
         x0   = !m_busy && req0_valid && !g;
         x1   = !m_busy && req1_valid && g;
         show = m_busy && cyc >= due;
         chk("ready0", req0_ready, x0);
         chk("ready1", req1_ready, x1);
         chk("busy", busy, m_busy);
         chk("rsp_valid", rsp_valid, show);
         chk("rsp_fields", {rsp_id, rsp_dbz, rsp_quo, rsp_rem}, show ? {e_id, e_dbz, e_q, e_r} : 10'd0);
      end
   end

   task automatic put(input bit w, input logic [3:0] dv, input logic [3:0] ds);
      @(negedge clk); #2;
      if (w) begin req1_valid = 1; req1_dvnd = dv; req1_dvsr = ds; end
      else begin req0_valid = 1; req0_dvnd = dv; req0_dvsr = ds; end
   endtask

   task automatic accept(input bit w);
      int n = 0;
      #1;
      while (!(w ? req1_ready : req0_ready) && n < 20) begin @(posedge clk); #1; n++; end
      chk("accept_wait", int'(n < 20), 1);
      @(posedge clk); #1;
      if (w) req1_valid = 0; else req0_valid = 0;
   endtask

   task automatic get(output int l);
      l = 0;
      do begin @(negedge clk); l++; end while (!rsp_valid && l < 40);
   endtask

   task automatic consume;
      #2 rsp_ready = 1;
      @(posedge clk); #1 rsp_ready = 0;
   endtask

   task automatic pulse_rst;
      @(negedge clk); #2 rst = 1;
      @(negedge clk); #2 rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      #2 rst = 0;
      put(0, 14, 3); accept(0); get(lat);
      chk("t1_lat", lat, 5); chk("t1_quo", rsp_quo, 4'b0100); chk("t1_rem", rsp_rem, 4'b0010);
      chk("t1_dbz", rsp_dbz, 0); chk("t1_id", rsp_id, 0);
      consume;
      put(1, 15, 2); accept(1); get(lat);
      chk("t2_lat", lat, 5); chk("t2_quo", rsp_quo, 4'b0111); chk("t2_rem", rsp_rem, 4'b0001); chk("t2_id", rsp_id, 1);
      consume;
      put(0, 13, 0); accept(0); get(lat);
      chk("t3_lat", lat, 1); chk("t3_quo", rsp_quo, 4'b1111); chk("t3_rem", rsp_rem, 4'b1101); chk("t3_dbz", rsp_dbz, 1);
      consume;
      // simultaneous requests straight after reset
      pulse_rst;
      @(negedge clk); #2;
      req0_valid = 1; req0_dvnd = 9; req0_dvsr = 4;
      req1_valid = 1; req1_dvnd = 7; req1_dvsr = 7;
      #1 chk("t4_grant0", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk); #1 req0_valid = 0;
      get(lat); chk("t4a_quo", rsp_quo, 4'b0010); chk("t4a_rem", rsp_rem, 4'b0001); chk("t4a_id", rsp_id, 0);
      consume;
      chk("t4_grant1", {req0_ready, req1_ready}, 2'b01);
      @(posedge clk); #1 req1_valid = 0;
      get(lat); chk("t4b_quo", rsp_quo, 4'b0001); chk("t4b_rem", rsp_rem, 4'b0000); chk("t4b_id", rsp_id, 1);
      consume;
      // result held with back-pressure while another request waits
      put(0, 14, 3); accept(0);
      #1 req1_valid = 1; req1_dvnd = 5; req1_dvsr = 1;
      get(lat);
      hq = rsp_quo; hr = rsp_rem;
      repeat (3) begin
         @(negedge clk);
         chk("t5_hold", {rsp_valid, rsp_quo, rsp_rem, req0_ready, req1_ready}, {1'b1, hq, hr, 2'b00});
      end
      consume;
      accept(1); get(lat);
      chk("t5_quo", rsp_quo, 4'b0101); chk("t5_rem", rsp_rem, 4'b0000); chk("t5_id", rsp_id, 1);
      consume;
      // reset during the second RUN cycle discards the operation
      put(0, 14, 3); accept(0);
      @(posedge clk); #3 rst = 1;
      #1 chk("t6_rst_out", {busy, rsp_valid, rsp_quo, rsp_rem, req0_ready, req1_ready}, 0);
      @(negedge clk); #2 rst = 0;
      @(negedge clk); #2;
      req0_valid = 1; req0_dvnd = 9; req0_dvsr = 4;
      req1_valid = 1; req1_dvnd = 7; req1_dvsr = 7;
      #1 chk("t6_grant0", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk); #1 req0_valid = 0;
      get(lat); chk("t6_quo", rsp_quo, 4'b0010); chk("t6_id", rsp_id, 0);
      consume;
      accept(1); get(lat); chk("t6b_id", rsp_id, 1);
      consume;
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter size, default 4, giving the operand/result width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operand pair.
REQ-005 SHALL have port req0_dvnd  input  size  requester 0 dividend.
REQ-006 SHALL have port req0_dvsr  input  size  requester 0 divisor.
REQ-007 SHALL have port req0_ready  output  1  requester 0 accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_dvnd, req1_dvsr and req1_ready, identical in direction, width and meaning for requester 1.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_id  output  1  requester owning the result.
REQ-011 SHALL have port rsp_quo  output  size  quotient.
REQ-012 SHALL have port rsp_rem  output  size  remainder.
REQ-013 SHALL have port rsp_dbz  output  1  divide-by-zero flag.
REQ-014 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 SHALL drive reqN_ready high only in IDLE, to at most one requester (the grant), and only while that requester's valid is high; ready SHALL be combinational from state, valids and the pointer.
REQ-018 SHALL arbitrate round-robin: with one valid requester, grant it; with both valid, grant the requester not served last; the pointer SHALL update only on an accepted handshake.
REQ-019 SHALL, on a handshake (valid & ready) in IDLE, latch dvnd, dvsr and id; go to RUN if dvsr != 0, otherwise go to DONE.
REQ-020 SHALL in RUN perform one restoring shift-subtract step per cycle for exactly size cycles, then go to DONE.
REQ-021 SHALL assert rsp_valid high in DONE with rsp_quo = dvnd / dvsr and rsp_rem = dvnd % dvsr (unsigned); the first cycle of rsp_valid SHALL be size+1 cycles after the accept edge.
REQ-022 SHALL handle dvsr == 0 as follows: rsp_quo all ones, rsp_rem = dvnd, rsp_dbz = 1; rsp_valid SHALL assert 1 cycle after the accept edge.
REQ-023 SHALL hold all rsp_* outputs stable in DONE while rsp_ready is low, and SHALL accept no new request.
REQ-024 SHALL return to IDLE on rsp_valid & rsp_ready; a new handshake SHALL be possible in the following cycle, not the same cycle.
REQ-025 SHALL keep rsp_valid, rsp_quo, rsp_rem and rsp_dbz at 0 outside DONE.
REQ-026 SHALL ignore requester inputs that change outside the accept cycle; they have no effect on a result in flight.

Reset
REQ-027 SHALL, while rst is high, force IDLE, the pointer to favour requester 0, and all outputs to 0 (busy 0, both ready 0, rsp_* 0).
REQ-028 SHALL, on rst asserted during RUN or DONE, discard the operation with no response; the first handshake after rst falls SHALL see reset grant order.

Structure
REQ-029 SHALL place the state encoding (IDLE, RUN, DONE) and the default size constant in the shared package div_pkg.
REQ-030 SHALL instantiate one sub-module, seq_div_core (remainder/quotient shift registers, step counter, load/step/done interface), sequenced by the div_sched FSM.

Verification
REQ-031 SHALL cover: req0 14/3 -> rsp_quo=0100, rsp_rem=0010, rsp_dbz=0, rsp_id=0, rsp_valid high 5 cycles after accept.
REQ-032 SHALL cover: req1 15/2 -> rsp_quo=0111, rsp_rem=0001, rsp_id=1.
REQ-033 SHALL cover: req0 13/0 -> rsp_quo=1111, rsp_rem=1101, rsp_dbz=1, rsp_valid high 1 cycle after accept.
REQ-034 SHALL cover: both valid after reset, holding (9/4, 7/7) -> req0 served first (q=0010 r=0001), then req1 (q=0001 r=0000); ready is never high to both.
REQ-035 SHALL cover: rsp_ready held low 3 cycles in DONE -> outputs unchanged, both ready low, result consumed on the 4th cycle.
REQ-036 SHALL cover: rst pulsed on the 2nd RUN cycle -> all outputs 0 immediately, no response, and the next simultaneous request grants req0.
